ca_grid_array: RTL
==================

// Module: ca_grid_array
// PURPOSE
//  Parametrised successor of the fixed 25x25 cell_core grid. Instantiates WIDTH x HEIGHT
//  cell_core instances sharing one broadcast instruction stream, with selectable toroidal
//  or fixed-border neighbourhood. Adds a host raster load/dump port and a step counter.
//  Sits between the control unit (instruction/pc/sp broadcast, consensus) and host DMA.
// PARAMETERS
//  WIDTH         25  grid columns (X); legal range >= 3
//  HEIGHT        25  grid rows (Y); legal range >= 3
//  WRAP          1   1 = toroidal edges; 0 = off-grid neighbours read BORDER_VALUE
//  BORDER_VALUE  0   value_t constant driven on off-grid neighbour inputs when WRAP=0
// PORTS
//  clk                   in   1              clock
//  rst                   in   1              synchronous, active-high reset
//  next_program_counter  in   pc_t           broadcast to every cell
//  next_stack_pointer    in   sp_t           broadcast to every cell
//  instruction           in   instruction_t  broadcast to every cell
//  global_enable         in   1              compute step request
//  diverge_consensus     out  1              AND of all cell diverge outputs (comb.)
//  busy                  out  1              1 while in LOAD or DUMP
//  load_start            in   1              begin raster load (honoured in IDLE only)
//  dump_start            in   1              begin raster dump (honoured in IDLE only)
//  in_valid/in_ready     in/out 1            load-word handshake
//  in_data               in   value_t        load word
//  out_valid/out_ready   out/in 1            dump-word handshake
//  out_data              out  value_t        dump word
//  out_last              out  1              high with final dump word
//  step_count            out  32             number of completed compute steps
// BEHAVIOUR
//  - Cell (x,y) gets X=x,Y=y; i11=own state, i01=(x,y-1), i21=(x,y+1), i10=(x-1,y),
//    i12=(x+1,y). WRAP=1: indices mod WIDTH/HEIGHT. WRAP=0: off-grid -> BORDER_VALUE.
//  - FSM states IDLE, LOAD, DUMP. Reset -> IDLE; all states[][]=0, step_count=0,
//    raster counters=0, busy=0, in_ready=0, out_valid=0, out_last=0.
//  - step_en = global_enable & (FSM==IDLE). step_en is the enable passed to cell_core and
//    gates states[][] <= nextState; step_count += 1 on step_en, wraps 2^32-1 -> 0.
//  - IDLE: load_start -> LOAD next cycle; else dump_start -> DUMP. Both high: LOAD wins,
//    dump_start dropped. Starts seen in LOAD/DUMP are ignored, not queued. The cycle a
//    start is accepted is still an IDLE cycle, so global_enable in that cycle steps.
//  - Raster order: x fastest, then y; index 0 = (0,0), last = (WIDTH-1,HEIGHT-1).
//  - LOAD: in_ready=1. On in_valid&in_ready, states[ly][lx] <= in_data, counter advances.
//    Acceptance of word WIDTH*HEIGHT-1 -> IDLE next cycle (in_ready drops). in_valid
//    low stalls with no change.
//  - DUMP: out_valid=1, out_data=states[dy][dx] (comb. mux), out_last=1 iff last index.
//    Advance on out_valid&out_ready; out_last accepted -> IDLE. out_ready low holds data.
//  - Load/dump counters reset to 0 on entry to LOAD/DUMP.
//  - global_enable during LOAD/DUMP: ignored; no state change, step_count frozen.
//  - rst mid-transfer: immediate return to IDLE, partial data discarded, grid zeroed.
//  - diverge_consensus stays combinational in every FSM state; not gated.
//  - Latency: load_start at cycle n -> in_ready=1 at n+1; min load = WIDTH*HEIGHT cycles.
// TESTING
//  1 WIDTH=HEIGHT=4, WRAP=1: load 0..15; dump -> 0..15, out_last only on 15.
//  2 WRAP=0, BORDER_VALUE=7: cell (0,0) neighbour-read instr -> i01=i10=7.
//    Same instr, WRAP=1 -> i01 = states[3][0], i10 = states[0][3].
//  3 global_enable=1 throughout a 16-word load: step_count unchanged, no cell update.
//    3 IDLE steps after -> step_count=3.
//  4 load_start & dump_start same cycle -> LOAD, in_ready=1.
//    dump_start during LOAD ignored -> IDLE after word 15.
//  5 rst after 5 load words -> busy=0, dump reads 16 zeros.
//    Random out_ready stalls: out_data stable while stalled.
//  6 All cells diverge=1 -> consensus=1; one cell 0 -> consensus=0 same cycle, any state.

Source files
------------

// File: rtl/ca_grid_array.sv
// Parametrised WIDTH x HEIGHT cellular-automaton grid: cell_core array fed by one broadcast
// instruction stream, with a host raster load/dump port and a compute-step counter.

package ca_pkg;
    typedef logic [7:0] value_t;
    typedef logic [7:0] pc_t;
    typedef logic [7:0] sp_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_LDN  = 4'd2,
        OP_LDS  = 4'd3,
        OP_LDW  = 4'd4,
        OP_LDE  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LDX  = 4'd7,
        OP_LDY  = 4'd8,
        OP_LDPC = 4'd9,
        OP_LDSP = 4'd10,
        OP_TEST = 4'd11
    } opcode_e;

    typedef struct packed {
        opcode_e opcode;
        value_t  imm;
    } instruction_t;
endpackage

// One grid cell: purely combinational next-state and divergence flag.
module cell_core
    import ca_pkg::*;
(
    input  logic         enable,
    input  value_t       pos_x,
    input  value_t       pos_y,
    input  value_t       i01,
    input  value_t       i21,
    input  value_t       i10,
    input  value_t       i11,
    input  value_t       i12,
    input  pc_t          next_program_counter,
    input  sp_t          next_stack_pointer,
    input  instruction_t instruction,
    output value_t       next_state,
    output logic         diverge
);
    value_t result;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        result  = i11;
        diverge = 1'b0;
        case (instruction.opcode)
            OP_LDI:  result = instruction.imm;
            OP_LDN:  result = i01;
            OP_LDS:  result = i21;
            OP_LDW:  result = i10;
            OP_LDE:  result = i12;
            OP_ADDI: result = i11 + instruction.imm;
            OP_LDX:  result = pos_x;
            OP_LDY:  result = pos_y;
            OP_LDPC: result = next_program_counter;
            OP_LDSP: result = next_stack_pointer;
            OP_TEST: diverge = (i11 == instruction.imm);
            default: result = i11;
        endcase
        next_state = enable ? result : i11;
    end
endmodule

module ca_grid_array
    import ca_pkg::*;
#(
    parameter int     WIDTH        = 25,
    parameter int     HEIGHT       = 25,
    parameter bit     WRAP         = 1'b1,
    parameter value_t BORDER_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  pc_t          next_program_counter,
    input  sp_t          next_stack_pointer,
    input  instruction_t instruction,
    input  logic         global_enable,
    output logic         diverge_consensus,
    output logic         busy,
    input  logic         load_start,
    input  logic         dump_start,
    input  logic         in_valid,
    output logic         in_ready,
    input  value_t       in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output value_t       out_data,
    output logic         out_last,
    output logic [31:0]  step_count
);
    localparam int CELLS = WIDTH * HEIGHT;
    localparam int XB    = $clog2(WIDTH);
    localparam int YB    = $clog2(HEIGHT);
    localparam logic [XB-1:0] X_LAST = XB'(WIDTH - 1);
    localparam logic [YB-1:0] Y_LAST = YB'(HEIGHT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DUMP = 2'd2;

    logic [1:0]     fsm;
    logic [XB-1:0]  cx;
    logic [YB-1:0]  cy;
    value_t         states     [HEIGHT][WIDTH];
    value_t         next_state [HEIGHT][WIDTH];
    logic [CELLS-1:0] diverge_vec;

    logic step_en, load_fire, dump_fire, advance, last_cell;

    assign step_en   = global_enable && (fsm == ST_IDLE);
    assign in_ready  = (fsm == ST_LOAD);
    assign out_valid = (fsm == ST_DUMP);
    assign busy      = (fsm != ST_IDLE);
    assign load_fire = in_ready && in_valid;
    assign dump_fire = out_valid && out_ready;
    assign advance   = load_fire || dump_fire;
    assign last_cell = (cx == X_LAST) && (cy == Y_LAST);
    assign out_last  = out_valid && last_cell;
    assign out_data  = states[cy][cx];
    assign diverge_consensus = &diverge_vec;

    for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_row
        for (genvar gx = 0; gx < WIDTH; gx++) begin : g_col
            localparam int YN = (gy == 0)          ? HEIGHT - 1 : gy - 1;
            localparam int YS = (gy == HEIGHT - 1) ? 0          : gy + 1;
            localparam int XL = (gx == 0)          ? WIDTH - 1  : gx - 1;
            localparam int XR = (gx == WIDTH - 1)  ? 0          : gx + 1;

            value_t i01, i21, i10, i12, cell_next;
            logic   cell_diverge;

            // Off-grid neighbours read the border constant unless the edges wrap.
            assign i01 = (!WRAP && gy == 0)          ? BORDER_VALUE : states[YN][gx];
            assign i21 = (!WRAP && gy == HEIGHT - 1) ? BORDER_VALUE : states[YS][gx];
            assign i10 = (!WRAP && gx == 0)          ? BORDER_VALUE : states[gy][XL];
            assign i12 = (!WRAP && gx == WIDTH - 1)  ? BORDER_VALUE : states[gy][XR];

            cell_core u_cell (
                .enable               (step_en),
                .pos_x                (value_t'(gx)),
                .pos_y                (value_t'(gy)),
                .i01                  (i01),
                .i21                  (i21),
                .i10                  (i10),
                .i11                  (states[gy][gx]),
                .i12                  (i12),
                .next_program_counter (next_program_counter),
                .next_stack_pointer   (next_stack_pointer),
                .instruction          (instruction),
                .next_state           (cell_next),
                .diverge              (cell_diverge)
            );

            assign next_state[gy][gx]       = cell_next;
            assign diverge_vec[gy*WIDTH+gx] = cell_diverge;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= ST_IDLE;
            cx         <= '0;
            cy         <= '0;
            step_count <= '0;
            // NOTE: the grid is built from flops, not a RAM, so it is cleared here in one cycle.
            for (int ry = 0; ry < HEIGHT; ry++) begin
                for (int rx = 0; rx < WIDTH; rx++) begin
                    states[ry][rx] <= '0;
                end
            end
        end else begin
            if (step_en) begin
                for (int ry = 0; ry < HEIGHT; ry++) begin
                    for (int rx = 0; rx < WIDTH; rx++) begin
                        states[ry][rx] <= next_state[ry][rx];
                    end
                end
                step_count <= step_count + 32'd1;
            end else if (load_fire) begin
                states[cy][cx] <= in_data;
            end

            // Holding the raster counters at zero while idle clears them on every entry.
            if (fsm == ST_IDLE || (advance && last_cell)) begin
                cx <= '0;
                cy <= '0;
            end else if (advance) begin
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end

            case (fsm)
                ST_IDLE: begin
                    if (load_start)      fsm <= ST_LOAD;
                    else if (dump_start) fsm <= ST_DUMP;
                end
                ST_LOAD, ST_DUMP: begin
                    if (advance && last_cell) fsm <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end
endmodule
